abs_saturation_pipe: RTL
========================

# abs_saturation_pipe

Pipelined, parametrised absolute-value unit for a stream of signed two's-complement samples. The block is width-generic and has valid/ready flow control on both sides. A per-beat mode selects saturating or wrapping handling of the most-negative input, and a saturating counter records most-negative events. It sits in the datapath between a signed sample source and magnitude consumers, such as peak detectors and scalers.

## Interface
- WIDTH, 8, input sample width in bits; legal range ≥ 2.
- CNT_WIDTH, 16, width of the most-negative event counter; legal range ≥ 1.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  signed two's-complement sample.
- sat_en  in  1  mode for this beat, sampled with the beat: 1 = saturate, 0 = wrap.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the output beat.
- out_data  out  WIDTH-1  unsigned magnitude.
- out_sat  out  1  this output beat came from the most-negative input (-2^(WIDTH-1)), in either mode.
- sat_count  out  CNT_WIDTH  number of accepted output beats with out_sat=1; saturates at all-ones.
- cnt_clr  in  1  synchronous clear of sat_count.

## Operation
- **Handshakes:**
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- **Pipeline structure:** two register stages.
  - S1 captures {in_data, sat_en}.
  - S2 holds the computed {out_data, out_sat}.
- **Stage advance rules:**
  - S2 loads when S1 is valid and (S2 is empty or an output transfer occurs).
  - S1 loads when an input transfer occurs.
  - in_ready = !S1_valid || S1 advancing into S2. This is a combinational path from out_ready.
  - in_ready is forced 0 while rst_n is low.
- **Magnitude function on sample x**, where M = -2^(WIDTH-1):
  - x ≥ 0: out_data = x[WIDTH-2:0], out_sat = 0.
  - M < x < 0: out_data = (~x + 1) truncated to WIDTH-1 bits, out_sat = 0.
  - x = M, sat_en = 1: out_data = 2^(WIDTH-1)-1 (all ones), out_sat = 1.
  - x = M, sat_en = 0: out_data = 0 (wrapped), out_sat = 1.
- **sat_en scope:** sat_en is bound to its beat. Changing sat_en affects only beats accepted after the change.
- **Output stability:** while out_valid=1 and out_ready=0, out_data and out_sat hold stable.
- **Ordering:** beats are never dropped, duplicated or reordered.
- **Counter:**
  - sat_count increments by 1 on each output transfer with out_sat=1.
  - It holds at 2^CNT_WIDTH-1 (no wrap).
  - cnt_clr=1 sets sat_count to 0 on the next edge. Clear wins over a simultaneous increment; that event is not counted.
- **Reset:**
  - rst_n low immediately clears S1_valid, S2_valid, out_valid, out_data, out_sat and sat_count to 0.
  - Beats in flight are discarded and never appear at the output.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_sat=0, sat_count=0, in_ready=0 while rst_n is low. in_ready=1 from the first cycle after release.
- **Latency:** a beat accepted at edge N is presented with out_valid=1 after edge N+1, provided out_ready was not stalling.
- **Throughput:** 1 beat/cycle with out_ready held high.
- **Capacity:** with out_ready low, the block absorbs at most 2 beats, after which in_ready=0.
- **Refill:** in the cycle out_ready returns high, in_ready=1. Simultaneous input and output transfers are legal.
- **Counter timing:** sat_count updates on the edge that completes the output transfer. It is visible the following cycle.
- **Parameter checks:** WIDTH < 2 or CNT_WIDTH < 1 is a configuration error (simulation $error).

## Test plan
All scenarios use WIDTH=8 and CNT_WIDTH=16 unless stated otherwise.
- **Reset:** assert rst_n=0 mid-stream with 2 beats in flight → immediately out_valid=0, out_data=0, sat_count=0, in_ready=0. After release, neither in-flight beat ever appears and in_ready=1.
- **Saturating stream:** sat_en=1, out_ready=1, inputs -128, -127, -1, 0, 127 on consecutive cycles → out_data 127, 127, 1, 0, 127, each 2 cycles after acceptance. out_sat=1 only on the first beat; sat_count=1.
- **Wrap mode:** sat_en toggled 1, 0, 1 with three -128 beats → out_data 127, 0, 127; out_sat=1 on all three; sat_count=3.
- **Backpressure:** in_valid=1 continuously with inputs 1, 2, 3, 4, out_ready=0 for 5 cycles → exactly 2 beats accepted, then in_ready=0. out_data holds 1 stable. After out_ready=1, outputs are 1, 2, 3, 4 in order with no gaps.
- **Counter limits (CNT_WIDTH=2):**
  - Five -128 beats → sat_count = 3.
  - Then cnt_clr=1 on the same edge as a -128 output transfer → sat_count = 0.
- **Width sweep (WIDTH=4):** all inputs -8..7 → out_data equals |x| for x ≠ -8; x=-8 gives 7 with sat_en=1 and 0 with sat_en=0.

Source files
------------

// File: rtl/abs_saturation_pipe.sv
// abs_saturation_pipe: two-stage valid/ready absolute-value pipeline for signed samples,
// with per-beat saturate/wrap handling of the most-negative value and an event counter.
module abs_saturation_pipe #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 sat_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-2:0]     out_data,
    output logic                 out_sat,
    output logic [CNT_WIDTH-1:0] sat_count,
    input  logic                 cnt_clr
);

    if (WIDTH < 2) begin : g_bad_width
        $error("abs_saturation_pipe: WIDTH must be >= 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("abs_saturation_pipe: CNT_WIDTH must be >= 1");
    end

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_data_q, s1_data_d;
    logic                 s1_sat_en_q, s1_sat_en_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [WIDTH-2:0]     s2_data_q, s2_data_d;
    logic                 s2_sat_q, s2_sat_d;
    logic [CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic                 in_xfer;
    logic                 out_xfer;
    logic                 s2_load;
    logic                 is_most_neg;
    logic [WIDTH-2:0]     neg_mag;
    logic [WIDTH-2:0]     mag;

    always_comb begin
        out_xfer = s2_valid_q && out_ready;
        s2_load  = s1_valid_q && (!s2_valid_q || out_xfer);
        in_ready = rst_n && (!s1_valid_q || s2_load);
        in_xfer  = in_valid && in_ready;
    end

    // Low bits of (~x + 1) depend only on the low bits of x, so the sign bit is not needed.
    always_comb begin
        is_most_neg = (s1_data_q == MOST_NEG);
        neg_mag     = ~s1_data_q[WIDTH-2:0] + (WIDTH-1)'(1);
        mag         = s1_data_q[WIDTH-2:0];
        if (is_most_neg) begin
            mag = s1_sat_en_q ? '1 : '0;
        end else if (s1_data_q[WIDTH-1]) begin
            mag = neg_mag;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_sat_en_d = s1_sat_en_q;
        if (in_xfer) begin
            s1_valid_d  = 1'b1;
            s1_data_d   = in_data;
            s1_sat_en_d = sat_en;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_data_d  = mag;
            s2_sat_d   = is_most_neg;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    // Clear takes priority; the transfer coinciding with a clear is not counted.
    always_comb begin
        sat_count_d = sat_count_q;
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (out_xfer && s2_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_sat_en_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_sat_q    <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_sat_en_q <= s1_sat_en_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_sat_q    <= s2_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign sat_count = sat_count_q;

endmodule
